lines_level_tracker: RTL and testbench
======================================

# lines_level_tracker

Tracks cleared-line totals and the current game level, and issues the `gen` strobe to the downstream level binary-to-BCD converter. It sits between the playfield line-clear logic and the level display path. It accepts line-clear batches over a valid/ready handshake and counts lines serially. It holds `level` stable while the downstream converter samples it.

## Interface
Parameters:
- `LVL_MAX`, 63: level saturation value; must fit 6 bits.
- `LINES_MAX`, 999: line-total saturation value.
- `CONV_CYCLES`, 12: downstream conversion length in cycles after `gen`.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `game_start`, in, 1: one-cycle pulse; restarts the game counters.
- `start_level`, in, 6: level loaded on `game_start`.
- `clr_valid`, in, 1: a line-clear batch is offered.
- `clr_count`, in, 3: number of lines in the batch (0–4; 5–7 treated as 4).
- `clr_ready`, out, 1: block can accept a batch.
- `lines`, out, 10: total lines cleared, saturating at `LINES_MAX`.
- `level`, out, 6: current level; feeds the converter's `bin`.
- `gen`, out, 1: one-cycle strobe to the converter.
- `lvl_up`, out, 1: one-cycle pulse when a batch raised the level.

## Operation
- Level rule: level = min(`LVL_MAX`, `start_level` + floor(lines since `game_start` / 10)).
- Decade counter `dec` (0–9) tracks lines modulo 10.
- States and transitions:
  - IDLE: `clr_ready`=1. A handshake (`clr_valid` & `clr_ready`) latches rem = min(`clr_count`, 4) and clears `chg`. Next state is ADD, or NOTIFY if rem=0.
  - ADD: one line per cycle. `lines`++ unless already at `LINES_MAX`.
    - If `lines` was already at `LINES_MAX`: `dec` and `level` are frozen for that line.
    - Otherwise `dec`++. When `dec` wraps 9→0, `level`++ unless at `LVL_MAX`; set `chg` when `level` changes.
    - rem--. Go to NOTIFY when rem reaches 0.
  - NOTIFY: if `chg`=1, assert `gen`=1 and `lvl_up`=1 for this cycle and go to HOLD. If `chg`=0, go to IDLE.
  - HOLD: wait `CONV_CYCLES` cycles, then go to IDLE. `level` is guaranteed constant during HOLD.
- `game_start` has synchronous priority over every state:
  - Loads `lines`=0, `dec`=0, `level`=`start_level` (clamped to `LVL_MAX`).
  - Aborts any batch in progress.
  - Enters NOTIFY with `chg` forced to 1 and `lvl_up` suppressed, so `gen` fires.
- A `clr_valid` that coincides with `game_start` is not accepted.
- `clr_valid` while `clr_ready`=0 is ignored. The upstream source holds `clr_valid` until it is accepted.

## Timing
- Reset values: `lines`=0, `level`=0, `dec`=0, `gen`=0, `lvl_up`=0, `clr_ready`=1, state IDLE.
- A batch of n lines accepted at edge T:
  - `lines` updates on edges T+1 through T+n.
  - NOTIFY occupies cycle T+n+1, so `gen` is high during T+n+1 if the level changed.
- `clr_ready` is low from T+1 until:
  - IDLE is re-entered after NOTIFY (no change), or
  - NOTIFY plus `CONV_CYCLES` HOLD cycles have elapsed.
- Consecutive `gen` pulses from batches are at least `CONV_CYCLES`+2 cycles apart.
- `game_start` at edge T gives `gen` high during cycle T+1. It can restart a conversion mid-HOLD; this is permitted because the converter restarts on `gen`.
- `rst_n` low mid-operation immediately forces all reset values. No pulse is emitted on exit from reset.

## Structure
- Shared package `tetris_pkg`:
  - State enum `lvl_state_t` (IDLE, ADD, NOTIFY, HOLD).
  - Constants `LVL_MAX`, `LINES_MAX`, `BCD_CONV_CYCLES`, `MAX_CLEAR`=4.
- Single module with no sub-module. The decade counter and hold counter are inline, with a 4-bit hold counter.

## Test plan
- Reset, then `game_start` with `start_level`=5 → next cycle `level`=5, `lines`=0, `gen`=1 for one cycle, `lvl_up`=0, `clr_ready` low for 13 cycles.
- Start at level 0; batches of 4, 4, 2 → `lines`=4, 8, 10. `gen` and `lvl_up` only after the third batch, 3 cycles after acceptance. `level`=1.
- Batch with `clr_count`=0 and one with `clr_count`=7 → the first changes nothing and gives no `gen`, with `clr_ready` low for 1 cycle. The second adds exactly 4 lines.
- `start_level`=60, then 40 lines in 4-line batches → `level` steps 61, 62, 63 and stays 63. `gen` fires only on the three changes. `lines`=40.
- Drive `lines` to 998, then a 4-line batch → `lines`=999; `level` unchanged, because `dec` and `level` freeze once `lines` is at `LINES_MAX`. Hold `clr_valid` high during HOLD → it is not accepted until `clr_ready` rises.
- `rst_n` low during ADD → outputs return to reset values asynchronously. `game_start` during HOLD → counters reload and `gen` is reissued the next cycle.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and constants for the line/level tracking path.
// Holds the tracker state encoding and the game-wide limits.
package tetris_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        NOTIFY,
        HOLD
    } lvl_state_t;

    localparam int LVL_MAX         = 63;
    localparam int LINES_MAX       = 999;
    localparam int BCD_CONV_CYCLES = 12;
    localparam int MAX_CLEAR       = 4;

    function automatic logic [2:0] clamp_clear(input logic [2:0] cnt);
        return (cnt > 3'(MAX_CLEAR)) ? 3'(MAX_CLEAR) : cnt;
    endfunction

endpackage

// File: rtl/lines_level_tracker_if.sv
// Line-clear batch handshake between the playfield and the tracker.
// The playfield side drives the batch; the tracker answers with ready.
interface lines_level_tracker_if;

    logic       clr_valid;
    logic [2:0] clr_count;
    logic       clr_ready;

    modport master (
        output clr_valid,
        output clr_count,
        input  clr_ready
    );

    modport slave (
        input  clr_valid,
        input  clr_count,
        output clr_ready
    );

endinterface

// File: rtl/lines_level_tracker.sv
// Serial line counter and level tracker feeding the level BCD converter.
// Level only moves outside HOLD so the converter sees a stable input.
module lines_level_tracker #(
    parameter int LVL_MAX     = tetris_pkg::LVL_MAX,
    parameter int LINES_MAX   = tetris_pkg::LINES_MAX,
    parameter int CONV_CYCLES = tetris_pkg::BCD_CONV_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_start,
    input  logic [5:0]           start_level,
    lines_level_tracker_if.slave clr,
    output logic [9:0]           lines,
    output logic [5:0]           level,
    output logic                 gen,
    output logic                 lvl_up
);

    import tetris_pkg::*;

    localparam logic [9:0] LINES_TOP = 10'(LINES_MAX);
    localparam logic [5:0] LVL_TOP   = 6'(LVL_MAX);
    localparam logic [3:0] HOLD_LAST = 4'(CONV_CYCLES - 1);

    lvl_state_t state;
    logic [3:0] dec;
    logic [2:0] rem;
    logic       chg;
    logic [3:0] hold_cnt;

    logic [5:0] start_clamp;
    logic [2:0] batch;
    logic       accept;
    logic       at_top;
    logic       dec_wrap;
    logic       lvl_step;
    logic       chg_nxt;
    logic       last_line;

    assign start_clamp = (start_level > LVL_TOP) ? LVL_TOP : start_level;
    assign batch       = clamp_clear(clr.clr_count);
    assign accept      = clr.clr_valid & clr.clr_ready;

    // Once the line total saturates, further lines leave dec and level alone.
    assign at_top    = (lines == LINES_TOP);
    assign dec_wrap  = (dec == 4'd9);
    assign lvl_step  = !at_top && dec_wrap && (level != LVL_TOP);
    assign chg_nxt   = chg | lvl_step;
    assign last_line = (rem == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lines         <= '0;
            level         <= '0;
            dec           <= '0;
            rem           <= '0;
            chg           <= 1'b0;
            hold_cnt      <= '0;
            gen           <= 1'b0;
            lvl_up        <= 1'b0;
            clr.clr_ready <= 1'b1;
        end else begin
            gen    <= 1'b0;
            lvl_up <= 1'b0;
            if (game_start) begin
                lines         <= '0;
                dec           <= '0;
                level         <= start_clamp;
                rem           <= '0;
                chg           <= 1'b1;
                hold_cnt      <= '0;
                gen           <= 1'b1;
                clr.clr_ready <= 1'b0;
                state         <= NOTIFY;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            rem           <= batch;
                            chg           <= 1'b0;
                            clr.clr_ready <= 1'b0;
                            state         <= (batch == 3'd0) ? NOTIFY : ADD;
                        end
                    end
                    ADD: begin
                        if (!at_top) begin
                            lines <= lines + 10'd1;
                            dec   <= dec_wrap ? 4'd0 : dec + 4'd1;
                            if (lvl_step)
                                level <= level + 6'd1;
                        end
                        chg <= chg_nxt;
                        rem <= rem - 3'd1;
                        // gen/lvl_up are registered, so raise them on NOTIFY entry
                        if (last_line) begin
                            state  <= NOTIFY;
                            gen    <= chg_nxt;
                            lvl_up <= chg_nxt;
                        end
                    end
                    NOTIFY: begin
                        if (chg) begin
                            hold_cnt <= HOLD_LAST;
                            state    <= HOLD;
                        end else begin
                            clr.clr_ready <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == 4'd0) begin
                            clr.clr_ready <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lines_level_tracker.sv
// Self-checking bench for lines_level_tracker: vector table, corner
// sequences and random batches against a lines/level arithmetic model.
module tb_lines_level_tracker;

    localparam int LM = 63;
    localparam int NM = 999;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_start = 1'b0;
    logic [5:0] start_level = '0;
    logic [9:0] lines;
    logic [5:0] level;
    logic       gen;
    logic       lvl_up;

    lines_level_tracker_if bus ();

    lines_level_tracker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_start  (game_start),
        .start_level (start_level),
        .clr         (bus),
        .lines       (lines),
        .level       (level),
        .gen         (gen),
        .lvl_up      (lvl_up)
    );

    always #5 clk = ~clk;

    int total_chk = 0;
    int pass_chk  = 0;
    int tot = 0;
    int st  = 0;

    typedef struct {
        int cnt;
        int exp_lines;
        int exp_level;
        int exp_gens;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input int act, input int exp);
        total_chk++;
        if (act == exp) pass_chk++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int m_lines();
        return (tot > NM) ? NM : tot;
    endfunction

    function automatic int m_level();
        int l;
        l = st + m_lines() / 10;
        return (l > LM) ? LM : l;
    endfunction

    task automatic do_batch(input int c, output int gcnt);
        int n, b, a, gen_at, ucnt, low, k;
        bit ch;
        n  = (c > 4) ? 4 : c;
        b  = m_level();
        tot += n;
        a  = m_level();
        ch = (a != b);
        @(negedge clk);
        k = 0;
        while (!bus.clr_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("batch_ready_wait", int'(bus.clr_ready), 1);
        bus.clr_valid = 1'b1;
        bus.clr_count = 3'(c);
        @(negedge clk);
        bus.clr_valid = 1'b0;
        gcnt = 0; ucnt = 0; gen_at = -1; low = 0; k = 1;
        while (k < 60) begin
            if (gen) begin gcnt++; gen_at = k; end
            if (lvl_up) ucnt++;
            if (bus.clr_ready) break;
            low++;
            k++;
            @(negedge clk);
        end
        chk("batch_lines", int'(lines), m_lines());
        chk("batch_level", int'(level), m_level());
        chk("batch_gen_count", gcnt, ch ? 1 : 0);
        chk("batch_gen_cycle", gen_at, ch ? n + 1 : -1);
        chk("batch_lvl_up_count", ucnt, ch ? 1 : 0);
        chk("batch_ready_low", low, n + 1 + (ch ? 12 : 0));
    endtask

    task automatic do_game_start(input int s);
        int gcnt, ucnt, low, k;
        @(negedge clk);
        game_start  = 1'b1;
        start_level = 6'(s);
        @(negedge clk);
        game_start = 1'b0;
        tot = 0;
        st  = (s > LM) ? LM : s;
        chk("gs_gen", int'(gen), 1);
        chk("gs_lvl_up", int'(lvl_up), 0);
        chk("gs_level", int'(level), m_level());
        chk("gs_lines", int'(lines), 0);
        gcnt = 0; ucnt = 0; low = 0; k = 1;
        while (k < 60) begin
            if (gen) gcnt++;
            if (lvl_up) ucnt++;
            if (bus.clr_ready) break;
            low++;
            k++;
            @(negedge clk);
        end
        chk("gs_gen_count", gcnt, 1);
        chk("gs_lvl_up_count", ucnt, 0);
        chk("gs_ready_low", low, 13);
    endtask

    initial begin
        int g, gsum, k, seen;
        tbl[0] = '{4, 4, 0, 0};
        tbl[1] = '{4, 8, 0, 0};
        tbl[2] = '{2, 10, 1, 1};
        tbl[3] = '{0, 10, 1, 0};
        tbl[4] = '{7, 14, 1, 0};

        bus.clr_valid = 1'b0;
        bus.clr_count = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_lines", int'(lines), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_gen", int'(gen), 0);
        chk("rst_lvl_up", int'(lvl_up), 0);
        chk("rst_ready", int'(bus.clr_ready), 1);

        do_game_start(5);

        do_game_start(0);
        for (int i = 0; i < 5; i++) begin
            do_batch(tbl[i].cnt, g);
            chk("tbl_lines", int'(lines), tbl[i].exp_lines);
            chk("tbl_level", int'(level), tbl[i].exp_level);
            chk("tbl_gens", g, tbl[i].exp_gens);
        end

        do_game_start(60);
        gsum = 0;
        for (int i = 0; i < 10; i++) begin
            do_batch(4, g);
            gsum += g;
        end
        chk("sat_lvl_gens", gsum, 3);
        chk("sat_lvl_level", int'(level), 63);
        chk("sat_lvl_lines", int'(lines), 40);

        // valid offered together with game_start and held through HOLD
        @(negedge clk);
        game_start    = 1'b1;
        start_level   = 6'd2;
        bus.clr_valid = 1'b1;
        bus.clr_count = 3'd3;
        @(negedge clk);
        game_start = 1'b0;
        k = 0; seen = 0;
        while (!bus.clr_ready && k < 40) begin
            if (lines != 0) seen = 1;
            k++;
            @(negedge clk);
        end
        if (lines != 0) seen = 1;
        chk("hold_ready_low", k, 13);
        chk("hold_no_accept", seen, 0);
        @(negedge clk);
        bus.clr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_then_accept", int'(lines), 3);
        tot = 3; st = 2;
        k = 0;
        while (!bus.clr_ready && k < 40) begin
            k++;
            @(negedge clk);
        end
        chk("hold_ready_back", int'(bus.clr_ready), 1);
        chk("hold_level", int'(level), m_level());

        do_game_start(0);
        for (int i = 0; i < 249; i++) do_batch(4, g);
        do_batch(2, g);
        chk("sat_998", int'(lines), 998);
        do_batch(4, g);
        chk("sat_999", int'(lines), 999);
        chk("sat_level", int'(level), 63);

        do_game_start(0);
        do_batch(4, g);
        do_batch(4, g);
        @(negedge clk);
        bus.clr_valid = 1'b1;
        bus.clr_count = 3'd2;
        @(negedge clk);
        bus.clr_valid = 1'b0;
        tot += 2;
        repeat (5) @(negedge clk);
        chk("midhold_level", int'(level), 1);
        chk("midhold_ready", int'(bus.clr_ready), 0);
        do_game_start(7);
        do_batch(3, g);

        @(negedge clk);
        k = 0;
        while (!bus.clr_ready && k < 40) begin
            k++;
            @(negedge clk);
        end
        bus.clr_valid = 1'b1;
        bus.clr_count = 3'd4;
        @(negedge clk);
        bus.clr_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lines", int'(lines), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_gen", int'(gen), 0);
        chk("arst_lvl_up", int'(lvl_up), 0);
        chk("arst_ready", int'(bus.clr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tot = 0; st = 0;
        gsum = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (gen || lvl_up) gsum++;
        end
        chk("arst_no_pulse", gsum, 0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0)
                do_game_start(int'($urandom_range(0, 63)));
            else
                do_batch(int'($urandom_range(0, 7)), g);
        end

        $display("%0d/%0d checks passed", pass_chk, total_chk);
        $finish;
    end

endmodule
